// File: rtl/wb_result_mux_pkg.sv
// Shared definitions for the writeback result selector.
// - state_e: controller state encoding (IDLE=0, WAIT=1, HOLD=2).
// - SRC_*: bit positions in src_sel. The op_type decoder uses these to build the select.
package wb_result_mux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam int unsigned SRC_ALU   = 0;
  localparam int unsigned SRC_COND  = 1;
  localparam int unsigned SRC_RAM   = 2;
  localparam int unsigned SRC_STACK = 3;
  localparam int unsigned SRC_RET   = 4;

endpackage

// File: rtl/onehot_mux.sv
// Combinational AND-OR selector with select-shape flags.
// Ports:
//   sel      in  N        one-hot select (zero or multi-hot flagged, not rejected)
//   data     in  N*WIDTH  packed inputs, input i at [i*WIDTH +: WIDTH]
//   result   out WIDTH    OR of every input whose select bit is set
//   is_zero  out 1        no select bit set
//   is_multi out 1        more than one select bit set
module onehot_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 5
) (
  input  logic [N-1:0]       sel,
  input  logic [N*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   result,
  output logic               is_zero,
  output logic               is_multi
);

  always_comb begin
    result = '0;
    for (int i = 0; i < N; i++) begin
      result = result | (data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

  assign is_zero  = (sel == '0);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign is_multi = |(sel & (sel - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/wb_result_mux.sv
// Writeback result selector: picks one of N_SRC result sources with a one-hot select,
// waits for multi-cycle sources, and holds the registered result on a valid/ready
// handshake towards the register file.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   issue_valid/rdy  decoder offers a result slot / block accepts it
//   src_sel          one-hot source select, all-zero = no writeback
//   dest_reg         destination register tag
//   src_data         packed sources, source i at [i*WIDTH +: WIDTH]
//   src_valid        per-source data valid
//   wb_valid/ready   registered result handshake towards the register file
//   wb_data/wb_dest  registered result and tag
//   sel_err/tmo_err  sticky: multi-hot select accepted / wait timed out
//   err_clr          synchronous clear of both sticky flags
module wb_result_mux
  import wb_result_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_SRC    = 5,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [N_SRC-1:0]       src_sel,
  input  logic [REG_BITS-1:0]    dest_reg,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_valid,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [WIDTH-1:0]       wb_data,
  output logic [REG_BITS-1:0]    wb_dest,
  output logic                   sel_err,
  output logic                   tmo_err,
  input  logic                   err_clr
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [N_SRC-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [REG_BITS-1:0] dest_q, dest_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                sel_err_q, sel_err_d;
  logic                tmo_err_q, tmo_err_d;

  logic [N_SRC-1:0]    mux_sel;
  logic [WIDTH-1:0]    mux_data;
  logic                mux_zero, mux_multi;
  logic                src_ok;
  logic                accept;

  // While waiting, the live select may already belong to the next instruction.
  assign mux_sel = (state_q == StWait) ? sel_q : src_sel;

  onehot_mux #(
    .WIDTH (WIDTH),
    .N     (N_SRC)
  ) u_mux (
    .sel      (mux_sel),
    .data     (src_data),
    .result   (mux_data),
    .is_zero  (mux_zero),
    .is_multi (mux_multi)
  );

  assign src_ok = |(src_valid & mux_sel);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    data_d      = data_q;
    dest_d      = dest_q;
    timer_d     = timer_q;
    // Clear first so that a set event below overrides it.
    sel_err_d   = sel_err_q & ~err_clr;
    tmo_err_d   = tmo_err_q & ~err_clr;
    issue_ready = (state_q == StIdle) || ((state_q == StHold) && wb_ready);
    accept      = issue_valid && issue_ready;

    case (state_q)
      StIdle, StHold: begin
        if ((state_q == StHold) && wb_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          if (mux_zero) begin
            state_d = StIdle;
          end else if (mux_multi) begin
            sel_err_d = 1'b1;
            state_d   = StIdle;
          end else if (src_ok) begin
            data_d  = mux_data;
            dest_d  = dest_reg;
            sel_d   = src_sel;
            state_d = StHold;
          end else begin
            dest_d  = dest_reg;
            sel_d   = src_sel;
            timer_d = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (src_ok) begin
          data_d  = mux_data;
          state_d = StHold;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      data_q    <= '0;
      dest_q    <= '0;
      timer_q   <= '0;
      sel_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      timer_q   <= timer_d;
      sel_err_q <= sel_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign wb_valid = (state_q == StHold);
  assign wb_data  = data_q;
  assign wb_dest  = dest_q;
  assign sel_err  = sel_err_q;
  assign tmo_err  = tmo_err_q;

endmodule
